// File: rtl/rr_grant_encoder.sv
// rtl/rr_grant_encoder.sv - four-requester round-robin arbiter with registered grant index
//
// Purpose:
//   Picks one of four requesters in round-robin order and presents its index
//   as a registered 2-bit grant plus a qualifying valid flag, ready to feed a
//   2-to-4 decoder. A grant lasts until the holder releases it, drops its
//   request, or reaches HOLD_MAX cycles (forced revocation with a one-cycle
//   timeout pulse). Every grant is followed by at least two cycles with no
//   grant, so the decoded one-hot vector never switches directly from one
//   requester to another.
//
// Parameters:
//   HOLD_MAX      maximum cycles a single grant may be held (2..255)
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   req[3:0]      request lines, bit i high means requester i wants the resource
//   hold_release  current holder is finished; only looked at while granting
//                 (the word "release" is reserved in SystemVerilog)
//   gnt_idx[1:0]  index of the granted requester, held while gnt_valid is low
//   gnt_valid     high while a grant is active
//   timeout       one-cycle pulse when a grant is revoked by the hold limit

module rr_grant_encoder #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       hold_release,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  // Last cycle index of a grant; reaching it ends the grant with a timeout.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [1:0] last_idx;
  logic [1:0] last_idx_nxt;
  logic [7:0] hold_cnt;
  logic [7:0] hold_cnt_nxt;
  logic [1:0] gnt_idx_nxt;
  logic       gnt_valid_nxt;
  logic       timeout_nxt;

  logic [1:0] win_idx;
  logic       win_found;
  logic       holder_done;
  logic       hold_expired;

  // Round-robin search starting just after the previous winner. Walking the
  // offsets from farthest to nearest lets the nearest requester overwrite the
  // others, so the last assignment is the highest-priority match.
  always_comb begin
    logic [1:0] cand;
    cand      = last_idx;
    win_idx   = last_idx;
    win_found = |req;
    for (int k = 4; k >= 1; k--) begin
      cand = last_idx + 2'(k);
      if (req[cand]) begin
        win_idx = cand;
      end
    end
  end

  // A voluntary end (release or request dropped) outranks the hold limit, so a
  // release landing on the final allowed cycle never raises timeout.
  assign holder_done  = hold_release | ~req[gnt_idx];
  assign hold_expired = (hold_cnt >= HOLD_LAST);

  // State register; the grant outputs are registered alongside it so no
  // input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt_idx   <= 2'b00;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      last_idx  <= 2'b11;
      hold_cnt  <= 8'd0;
    end else begin
      state     <= state_nxt;
      gnt_idx   <= gnt_idx_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
      last_idx  <= last_idx_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (holder_done || hold_expired) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output / datapath logic: values the registers take at the next edge.
  always_comb begin
    gnt_idx_nxt   = gnt_idx;
    gnt_valid_nxt = 1'b0;
    timeout_nxt   = 1'b0;
    last_idx_nxt  = last_idx;
    hold_cnt_nxt  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          gnt_idx_nxt   = win_idx;
          gnt_valid_nxt = 1'b1;
          last_idx_nxt  = win_idx;
          hold_cnt_nxt  = 8'd0;
        end
      end
      ST_GRANT: begin
        if (holder_done) begin
          gnt_valid_nxt = 1'b0;
        end else if (hold_expired) begin
          timeout_nxt   = 1'b1;
        end else begin
          // Counter only advances below the limit, so it saturates there.
          gnt_valid_nxt = 1'b1;
          hold_cnt_nxt  = hold_cnt + 8'd1;
        end
      end
      default: begin
        gnt_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_grant_encoder.sv
// tb/tb_rr_grant_encoder.sv - scoreboard bench for rr_grant_encoder
module tb_rr_grant_encoder;

  localparam int HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rel;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  rr_grant_encoder #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .hold_release (rel),
    .gnt_idx      (gnt_idx),
    .gnt_valid    (gnt_valid),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int idx;
    int start;
    int len;
    int to;
  } exp_t;

  exp_t sb[$];
  int   last_ptr = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbitration: first requester after the previous winner, mod 4.
  function automatic int pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last_ptr + k) % 4]) return (last_ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One grant: mode 0 = release after len cycles, 1 = drop own request after
  // len cycles, 2 = hold until the limit revokes it.
  task automatic txn(input logic [3:0] r, input int mode, input int len,
                     input int idle, input bit noise);
    int   w;
    int   e;
    exp_t x;
    for (int i = 0; i < idle; i++) begin
      req = 4'b0000;
      rel = noise && (i == 0);
      tick();
    end
    rel = 1'b0;
    req = r;
    w   = pick(r);
    e   = cyc + 1;
    x.idx   = w;
    x.start = e;
    x.len   = (mode == 2) ? HOLD_MAX : len;
    x.to    = (mode == 2) ? 1 : 0;
    sb.push_back(x);
    last_ptr = w;
    tick();
    for (int j = 1; j < x.len; j++) begin
      if (noise) req = 4'($urandom) | (4'b0001 << w);
      tick();
    end
    if (mode == 0) rel = 1'b1;
    else if (mode == 1) req = (noise ? 4'($urandom) : r) & ~(4'b0001 << w);
    tick();
    // Gap cycle: release and new requests here must be ignored.
    rel = noise ? 1'($urandom) : 1'b0;
    if (noise) req = 4'($urandom);
    tick();
    rel = 1'b0;
  endtask

  task automatic reset_txn(input logic [3:0] r, input int k);
    exp_t x;
    req     = r;
    x.idx   = pick(r);
    x.start = cyc + 1;
    x.len   = k;
    x.to    = 0;
    sb.push_back(x);
    tick();
    for (int j = 1; j < k; j++) tick();
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    last_ptr = 3;
    @(negedge clk);
    check("rst_mid_gnt_idx", gnt_idx, 0);
    check("rst_mid_gnt_valid", gnt_valid, 0);
    check("rst_mid_timeout", timeout, 0);
  endtask

  // Monitor: rebuilds each grant from the outputs and pops its expectation.
  int   cur_idx;
  int   cur_start;
  int   cur_len;
  bit   prev_valid = 1'b0;
  exp_t got_x;

  initial begin
    forever begin
      @(negedge clk);
      if (gnt_valid === 1'b1) begin
        if (!prev_valid) begin
          cur_idx   = int'(gnt_idx);
          cur_start = cyc;
          cur_len   = 1;
        end else begin
          cur_len++;
          check("idx_stable", gnt_idx, cur_idx);
        end
        check("timeout_in_grant", timeout, 0);
      end else begin
        if (prev_valid) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_grant: got idx %0d at cycle %0d, expected none", cur_idx, cur_start);
          end else begin
            got_x = sb.pop_front();
            check("grant_idx", cur_idx, got_x.idx);
            check("grant_start", cur_start, got_x.start);
            check("grant_len", cur_len, got_x.len);
            check("grant_timeout", timeout, got_x.to);
          end
        end else begin
          check("timeout_idle", timeout, 0);
        end
      end
      prev_valid = (gnt_valid === 1'b1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    rel = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_gnt_idx", gnt_idx, 0);
    check("reset_gnt_valid", gnt_valid, 0);
    check("reset_timeout", timeout, 0);
    rst = 1'b0;
    tick();

    // Alternating pair with release after three cycles: idx 1 then 3.
    txn(4'b1010, 0, 3, 0, 1'b0);
    txn(4'b1010, 0, 3, 0, 1'b0);
    // All requesting, never released: 0,1,2,3,0 each timing out.
    last_ptr = last_ptr;
    txn(4'b1111, 2, 0, 1, 1'b0);
    txn(4'b1111, 2, 0, 0, 1'b0);
    txn(4'b1111, 2, 0, 0, 1'b0);
    txn(4'b1111, 2, 0, 0, 1'b0);
    txn(4'b1111, 2, 0, 0, 1'b0);
    // Requester 2 alone, drops its request.
    txn(4'b0100, 1, 3, 1, 1'b0);
    // Release on the final allowed cycle: no timeout.
    txn(4'b1111, 0, HOLD_MAX, 0, 1'b0);
    // Reset during a grant of idx 2, then pointer restarts at 0.
    reset_txn(4'b0100, 2);
    txn(4'b1111, 0, 2, 0, 1'b0);
    // Release pulse while idle is ignored; requester 0 follows.
    txn(4'b0001, 0, 2, 2, 1'b1);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        reset_txn(4'($urandom_range(1, 15)), $urandom_range(1, HOLD_MAX));
      end else begin
        txn(4'($urandom_range(1, 15)), $urandom_range(0, 2),
            $urandom_range(1, HOLD_MAX), $urandom_range(0, 3), 1'b1);
      end
    end

    req = 4'b0000;
    rel = 1'b0;
    repeat (4) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
